// File: rtl/cmd_arbiter.sv
// Purpose: shares the 8-bit game command channel between manual and auto sources, gated by the latched active mode.
// Latency: ack and first tx_valid one cycle after a request is sampled in IDLE; all outputs registered.
// Backpressure: tx_ready low stalls SEND/REL with out_bits held stable; HOLD length is fixed and ignores tx_ready.
module cmd_arbiter #(
  parameter int          HOLD_CYCLES  = 16,
  parameter logic [7:0]  RELEASE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       man_req,
  input  logic [7:0] man_cmd,
  output logic       man_ack,
  input  logic       auto_req,
  input  logic [7:0] auto_cmd,
  output logic       auto_ack,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] out_bits,
  output logic       active_mode,
  output logic       busy,
  output logic       mode_pending
);

  localparam int            CW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, REL} state_t;

  state_t        state, state_nx;
  logic [7:0]    cmd_q, cmd_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          act_nx;
  logic          man_ack_nx, auto_ack_nx;
  logic          elig;
  logic          tx_valid_nx, busy_nx, pend_nx;
  logic [7:0]    out_nx;

  // Next-state and next-output decode; outputs are derived from the state being entered so they can be registered.
  always_comb begin
    state_nx    = state;
    cmd_nx      = cmd_q;
    cnt_nx      = cnt_q;
    act_nx      = active_mode;
    man_ack_nx  = 1'b0;
    auto_ack_nx = 1'b0;
    elig        = 1'b0;
    case (state)
      IDLE: begin
        // The mode update and the request sample share one edge, so eligibility uses the incoming mode.
        act_nx = mode;
        elig   = mode ? auto_req : man_req;
        if (elig) begin
          cmd_nx      = mode ? auto_cmd : man_cmd;
          man_ack_nx  = ~mode;
          auto_ack_nx = mode;
          state_nx    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          cnt_nx   = HOLD_LOAD;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // Counter saturates at zero; the zero cycle is the last HOLD cycle.
        if (cnt_q == '0) state_nx = REL;
        else             cnt_nx   = cnt_q - 1'b1;
      end
      REL: begin
        if (tx_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    tx_valid_nx = (state_nx == SEND) || (state_nx == REL);
    out_nx      = ((state_nx == SEND) || (state_nx == HOLD)) ? cmd_nx : RELEASE_BYTE;
    busy_nx     = (state_nx != IDLE);
    pend_nx     = (mode != act_nx) && busy_nx;
  end

  // State, latched command and hold counter; reset drops any command in flight without a release byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= RELEASE_BYTE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      cmd_q <= cmd_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bits     <= RELEASE_BYTE;
      tx_valid     <= 1'b0;
      man_ack      <= 1'b0;
      auto_ack     <= 1'b0;
      active_mode  <= 1'b0;
      busy         <= 1'b0;
      mode_pending <= 1'b0;
    end else begin
      out_bits     <= out_nx;
      tx_valid     <= tx_valid_nx;
      man_ack      <= man_ack_nx;
      auto_ack     <= auto_ack_nx;
      active_mode  <= act_nx;
      busy         <= busy_nx;
      mode_pending <= pend_nx;
    end
  end

endmodule

// File: doc/cmd_arbiter.md
# cmd_arbiter

Sequences and shares the single 8-bit game command channel (`out_bits`, driven into the UART transmitter and mirrored onto `led2[7:4]`) between the manual-control path and the auto script engine. Only the source selected by the latched active mode may issue commands. Each accepted command is sent, held on the channel for a fixed number of cycles so the game registers it, then followed by a release byte. Mode changes requested mid-command are deferred until the channel is idle.

## Interface
Parameters:
- `HOLD_CYCLES`, default 16: cycles a command stays on `out_bits` after the transmitter accepts it; legal range ≥1.
- `RELEASE_BYTE`, default 8'h00: byte sent after every hold to release the game input.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `mode`  in  1  requested mode: 0 manual, 1 auto.
- `man_req`  in  1  manual path has a command pending (level).
- `man_cmd`  in  8  manual command byte, valid while `man_req`=1.
- `man_ack`  out  1  one-cycle pulse: manual command accepted.
- `auto_req`  in  1  script engine has a command pending (level).
- `auto_cmd`  in  8  auto command byte, valid while `auto_req`=1.
- `auto_ack`  out  1  one-cycle pulse: auto command accepted.
- `tx_ready`  in  1  UART transmitter can take a byte this cycle.
- `tx_valid`  out  1  `out_bits` holds a byte to transmit.
- `out_bits`  out  8  command channel to UART and LED mirror.
- `active_mode`  out  1  mode currently in force.
- `busy`  out  1  1 in any state other than IDLE.
- `mode_pending`  out  1  `mode` ≠ `active_mode` while busy.

## Operation
- Reset (`rst_n`=0 at a clock edge) forces: state IDLE, `out_bits`=`RELEASE_BYTE`, `tx_valid`=0, both acks 0, `active_mode`=0, `busy`=0, `mode_pending`=0, hold counter 0. Reset takes effect from any state, including mid-command; the interrupted command is dropped without a release byte.
- The FSM has four states: IDLE, SEND, HOLD and REL.
- IDLE:
  - `active_mode` ← `mode` every cycle.
  - The eligible request is `man_req` when the new `active_mode`=0, or `auto_req` when it is 1. The other source is ignored and never acked.
  - If the eligible request is high: latch its cmd byte, pulse the matching ack for exactly one cycle, and go to SEND.
- SEND:
  - `tx_valid`=1 and `out_bits`=latched cmd.
  - On `tx_valid`&`tx_ready`: load counter with `HOLD_CYCLES`-1 and go to HOLD.
- HOLD:
  - `tx_valid`=0 and `out_bits`=latched cmd.
  - Counter decrements each cycle; at counter=0 go to REL.
- REL:
  - `tx_valid`=1 and `out_bits`=`RELEASE_BYTE`.
  - On `tx_ready`: go to IDLE.
- Outside IDLE, `active_mode` is frozen. `mode_pending`=(`mode`≠`active_mode`)&`busy`, registered.
- The counter is `$clog2(HOLD_CYCLES)+1` bits wide and unsigned, with no wrap. `HOLD_CYCLES`=1 gives exactly one HOLD cycle.
- A request held high across completion is re-arbitrated in IDLE and accepted again. Requesters deassert `req` on ack.

## Timing
- All outputs are registered.
- Request high in IDLE at edge N: ack=1 and `tx_valid`=1 after edge N+1. Ack falls after edge N+2 regardless of `tx_ready`.
- `tx_ready` stalls in SEND or REL extend that state indefinitely, and `out_bits` stays stable.
- Minimum command occupancy with `tx_ready` tied high: 1 SEND + `HOLD_CYCLES` HOLD + 1 REL + 1 IDLE cycle. For the default that is 19 cycles between acks.
- Mode change in IDLE applies at the same edge that samples requests. With `mode` 0→1 and `auto_req`=1 together, the auto command is accepted on that edge.
- `mode_pending` rises one cycle after `mode` changes while busy. It clears on the edge entering IDLE.

## Test plan
- Reset mid-HOLD: assert `rst_n`=0 during HOLD → next cycle `out_bits`=8'h00, `tx_valid`=0, `busy`=0, `active_mode`=0, no release byte sent.
- Manual command, `tx_ready`=1, `HOLD_CYCLES`=16: `man_cmd`=8'h24 → `man_ack` one cycle; 8'h24 on `out_bits` for 17 cycles; then 8'h00 with `tx_valid`=1 for one cycle; `busy` low at cycle 19.
- Wrong-source request: mode=0, `auto_req`=1 with `auto_cmd`=8'h3C for 50 cycles → `auto_ack` never pulses and `out_bits` stays 8'h00.
- Mode switch while busy: toggle `mode` to 1 during HOLD with `auto_req`=1 → `mode_pending`=1 until IDLE; then `active_mode`=1 and `auto_ack` pulses in the same IDLE cycle.
- Stall: hold `tx_ready`=0 for 10 cycles in SEND, then in REL → `out_bits` stays 8'h24 and 8'h00 respectively; HOLD length stays exactly 16.
- Back-to-back: `man_req` held high with `HOLD_CYCLES`=1 and `tx_ready`=1 → acks exactly 4 cycles apart.
